// File: rtl/redun_mont_pkg.sv
// Shared constants, operand types and FSM encoding for the redundant Montgomery squaring sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: word/operand geometry, iteration counter width, normalisation threshold,
//           redun0_t operand type, controller state enum, flat<->redun0_t packing helpers.
package redun_mont_pkg;

  localparam int NUM_WRDS           = 65;
  localparam int WRD_BITS           = 16;
  localparam int WRD_W              = WRD_BITS + 1;
  localparam int OP_W               = NUM_WRDS * WRD_W;
  localparam int T_LEN              = 64;
  localparam int BOUNDARY_THRESHOLD = 2;
  // The normaliser is built as a fixed two-stage pipeline; this documents its latency.
  localparam int NORM_LAT           = 2;
  localparam int THR_W              = $clog2(BOUNDARY_THRESHOLD + 1);

  // One redundant word: WRD_BITS payload bits plus one carry-headroom bit.
  typedef logic [WRD_BITS:0]         rwrd_t;
  typedef rwrd_t [NUM_WRDS-1:0]      redun0_t;
  typedef logic [OP_W-1:0]           redun_flat_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_NORM,
    ST_DONE
  } sq_state_t;

  function automatic redun0_t unpack_redun(input redun_flat_t flat);
    return redun0_t'(flat);
  endfunction

  function automatic redun_flat_t pack_redun(input redun0_t r);
    return redun_flat_t'(r);
  endfunction

endpackage

// File: rtl/redun_mont_norm.sv
// Carry normaliser: folds each word's headroom bit into the next word, top carry discarded.
// Latency: NORM_LAT (2) cycles from i_val to o_val, fully pipelined.
// Backpressure: none; one result per accepted input, consumer must take o_val when it fires.
// Ports: i_clk/i_rst clock and synchronous reset; i_val/i_dat operand in; o_val/o_dat result out.
module redun_mont_norm
  import redun_mont_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_val,
  input  redun0_t i_dat,
  output logic    o_val,
  output redun0_t o_dat
);

  // Lower half of the carry chain in stage 1, upper half in stage 2.
  localparam int LO_WRDS = (NUM_WRDS + 1) / 2;

  // A word (max 2^17-1) plus an incoming carry (max 2) never exceeds 18 bits,
  // so the carry between words is at most 2 and fits in 2 bits.
  logic [WRD_BITS+1:0] s1_sum;
  logic [WRD_BITS+1:0] s2_sum;
  logic [1:0]          s1_cy;
  logic [1:0]          s2_cy;
  redun0_t             s1_dat;
  redun0_t             s2_dat;

  logic                s1_val_q;
  logic [1:0]          s1_cy_q;
  redun0_t             s1_dat_q;

  always_comb begin
    s1_dat = i_dat;
    s1_cy  = '0;
    s1_sum = '0;
    for (int i = 0; i < LO_WRDS; i++) begin
      s1_sum    = {1'b0, i_dat[i]} + {{WRD_BITS{1'b0}}, s1_cy};
      s1_dat[i] = {1'b0, s1_sum[WRD_BITS-1:0]};
      s1_cy     = s1_sum[WRD_BITS+1:WRD_BITS];
    end
  end

  always_comb begin
    s2_dat = s1_dat_q;
    s2_cy  = s1_cy_q;
    s2_sum = '0;
    for (int i = LO_WRDS; i < NUM_WRDS; i++) begin
      s2_sum    = {1'b0, s1_dat_q[i]} + {{WRD_BITS{1'b0}}, s2_cy};
      s2_dat[i] = {1'b0, s2_sum[WRD_BITS-1:0]};
      s2_cy     = s2_sum[WRD_BITS+1:WRD_BITS];
    end
    // Carry out of the top word is dropped: the top word is pure headroom.
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_val_q <= 1'b0;
      s1_cy_q  <= '0;
      s1_dat_q <= '0;
      o_val    <= 1'b0;
      o_dat    <= '0;
    end else begin
      s1_val_q <= i_val;
      o_val    <= s1_val_q;
      if (i_val) begin
        s1_dat_q <= s1_dat;
        s1_cy_q  <= s1_cy;
      end
      if (s1_val_q) begin
        o_dat <= s2_dat;
      end
    end
  end

endmodule

// File: rtl/redun_mont_sq_ctrl.sv
// Sequencer issuing T back-to-back redundant Montgomery squarings, with carry normalisation passes.
// Latency: T=0 -> o_done 2 cycles after start; per squaring 1 + multiplier latency + rdy wait, +3 per normalisation.
// Backpressure: o_mul_val/o_mul_dat held until i_mul_rdy; one multiplier op outstanding; i_start ignored while busy.
// Ports: i_clk/i_rst; command i_start,i_t,i_sq; status o_busy,o_done,o_sq,o_iter;
//        multiplier o_mul_val,o_mul_dat,i_mul_rdy (issue) and i_mul_val,i_mul_dat,i_mul_carry (return).
module redun_mont_sq_ctrl
  import redun_mont_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [T_LEN-1:0] i_t,
  input  logic [OP_W-1:0]  i_sq,
  output logic             o_busy,
  output logic             o_done,
  output logic [OP_W-1:0]  o_sq,
  output logic [T_LEN-1:0] o_iter,
  output logic             o_mul_val,
  output logic [OP_W-1:0]  o_mul_dat,
  input  logic             i_mul_rdy,
  input  logic             i_mul_val,
  input  logic [OP_W-1:0]  i_mul_dat,
  input  logic             i_mul_carry
);

  sq_state_t        state;
  sq_state_t        state_nxt;

  logic [T_LEN-1:0] t_lim;
  redun0_t          op;
  logic [THR_W-1:0] thr_cnt;
  logic             norm_busy;

  logic             accept;
  logic             mul_take;
  logic             norm_go;
  logic             norm_wb;
  logic             done_go;

  logic [T_LEN-1:0] iter_inc;
  logic [THR_W-1:0] thr_inc;

  logic             norm_o_val;
  redun0_t          norm_o_dat;

  // o_iter can never sit at all-ones here: completion is caught by equality with t_lim first.
  assign iter_inc  = o_iter + T_LEN'(1);
  assign thr_inc   = thr_cnt + THR_W'(1);
  assign o_mul_dat = pack_redun(op);

  redun_mont_norm u_norm (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_val (norm_go),
    .i_dat (op),
    .o_val (norm_o_val),
    .o_dat (norm_o_dat)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    mul_take  = 1'b0;
    norm_go   = 1'b0;
    norm_wb   = 1'b0;
    done_go   = 1'b0;
    o_mul_val = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          accept    = 1'b1;
          state_nxt = (i_t == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        o_mul_val = 1'b1;
        if (i_mul_rdy) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_mul_val) begin
          mul_take = 1'b1;
          // Normalisation takes priority over completion so the final result is normalised when needed.
          if (i_mul_carry || (thr_inc >= THR_W'(BOUNDARY_THRESHOLD))) begin
            state_nxt = ST_NORM;
          end else if (iter_inc == t_lim) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_ISSUE;
          end
        end
      end
      ST_NORM: begin
        // Launch once on entry; wait for the pipeline to return the normalised operand.
        norm_go = !norm_busy;
        if (norm_o_val) begin
          norm_wb   = 1'b1;
          state_nxt = (o_iter == t_lim) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE: begin
        done_go   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      t_lim     <= '0;
      op        <= '0;
      thr_cnt   <= '0;
      norm_busy <= 1'b0;
      o_iter    <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_sq      <= '0;
    end else begin
      o_done <= 1'b0;
      if (accept) begin
        t_lim   <= i_t;
        op      <= unpack_redun(i_sq);
        o_iter  <= '0;
        thr_cnt <= '0;
        o_busy  <= 1'b1;
      end
      if (mul_take) begin
        op      <= unpack_redun(i_mul_dat);
        o_iter  <= iter_inc;
        thr_cnt <= thr_inc;
      end
      if (norm_go) begin
        norm_busy <= 1'b1;
      end
      if (norm_wb) begin
        op        <= norm_o_dat;
        thr_cnt   <= '0;
        norm_busy <= 1'b0;
      end
      if (done_go) begin
        o_done <= 1'b1;
        o_sq   <= pack_redun(op);
        o_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_redun_mont_sq_ctrl.sv
// Bench for redun_mont_sq_ctrl: table of directed runs, hand sequences for stall/reset/busy-start,
// and randomized runs scored against a reference model of the squaring/normalisation rules.
// The multiplier is a behavioural responder (small-modulus Montgomery, forced value, or random data).
module tb_redun_mont_sq_ctrl;
  import redun_mont_pkg::*;

  typedef logic [OP_W-1:0] flat_t;
  localparam int ACC_W = NUM_WRDS * WRD_BITS + 8;
  typedef logic [ACC_W-1:0] acc_t;
  localparam longint unsigned MOD_N = 64'd65521;
  localparam int M_MONT  = 0;
  localparam int M_FORCE = 1;
  localparam int M_RAND  = 2;

  typedef struct {
    int unsigned     t;
    redun0_t         sq;
    int              mode;
    int              lat;
    int unsigned     f_w0;
    int unsigned     f_w1;
    bit              f_cy;
    bit              by_mont;
    int unsigned     exp_w0;
    int unsigned     exp_w1;
    longint unsigned exp_plain;
    int              exp_lat;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [T_LEN-1:0] t_in;
  flat_t            sq_in;
  logic             busy;
  logic             done;
  flat_t            sq_out;
  logic [T_LEN-1:0] iter;
  logic             mul_val;
  flat_t            mul_dat;
  logic             mul_rdy;
  logic             mul_rval;
  flat_t            mul_rdat;
  logic             mul_carry;

  int               n_checks = 0;
  int               n_errors = 0;
  int               mode = M_MONT;
  int               mul_lat = 4;
  bit               rdy_rand = 1'b0;
  bit               rdy_level = 1'b1;
  int unsigned      f_w0 = 0;
  int unsigned      f_w1 = 0;
  bit               f_cy = 1'b0;
  redun0_t          model_op = '0;
  int               model_cnt = 0;
  int               issue_cnt = 0;
  longint unsigned  rinv = 0;

  always #5 clk = ~clk;

  redun_mont_sq_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_t         (t_in),
    .i_sq        (sq_in),
    .o_busy      (busy),
    .o_done      (done),
    .o_sq        (sq_out),
    .o_iter      (iter),
    .o_mul_val   (mul_val),
    .o_mul_dat   (mul_dat),
    .i_mul_rdy   (mul_rdy),
    .i_mul_val   (mul_rval),
    .i_mul_dat   (mul_rdat),
    .i_mul_carry (mul_carry)
  );

  task automatic chk_int(input string nm, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input redun0_t act, input redun0_t exp);
    int idx;
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      idx = 0;
      for (int i = NUM_WRDS - 1; i >= 0; i--) begin
        if (act[i] !== exp[i]) idx = i;
      end
      $display("FAIL %s: word %0d got %h expected %h", nm, idx, act[idx], exp[idx]);
    end
  endtask

  // Reference normaliser: treat the operand as one integer sum(word_i * 2^(16*i)),
  // truncate to NUM_WRDS*16 bits and re-split into clean 16-bit words.
  function automatic redun0_t norm_ref(input redun0_t r);
    acc_t    acc;
    redun0_t o;
    acc = '0;
    for (int i = 0; i < NUM_WRDS; i++) acc = acc + (acc_t'(r[i]) << (WRD_BITS * i));
    o = '0;
    for (int i = 0; i < NUM_WRDS; i++) o[i] = {1'b0, acc[WRD_BITS*i +: WRD_BITS]};
    return o;
  endfunction

  function automatic longint unsigned op_int(input redun0_t r);
    return 64'(r[0]) + (64'(r[1]) << 16) + (64'(r[2]) << 32);
  endfunction

  function automatic longint unsigned modpow(input longint unsigned b, input longint unsigned e);
    longint unsigned res, base, ex;
    res = 1; base = b % MOD_N; ex = e;
    while (ex != 0) begin
      if (ex[0]) res = (res * base) % MOD_N;
      base = (base * base) % MOD_N;
      ex = ex >> 1;
    end
    return res;
  endfunction

  function automatic redun0_t to_mont(input longint unsigned x);
    redun0_t r;
    r = '0;
    r[0] = 17'((x << 16) % MOD_N);
    return r;
  endfunction

  function automatic longint unsigned from_mont(input redun0_t r);
    return ((op_int(r) % MOD_N) * rinv) % MOD_N;
  endfunction

  function automatic redun0_t two_words(input int unsigned w0, input int unsigned w1);
    redun0_t r;
    r = '0;
    r[0] = 17'(w0);
    r[1] = 17'(w1);
    return r;
  endfunction

  // Ready driver: either a fixed level or a coin toss each cycle.
  initial begin : rdy_drv
    mul_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      mul_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_level;
    end
  end

  // Behavioural multiplier plus model update: every issued operand is compared with the model,
  // the response is chosen by mode, and the model applies the normalisation rules to it.
  initial begin : responder
    redun0_t         resp;
    bit              cy;
    longint unsigned a, s;
    mul_rval = 1'b0; mul_rdat = '0; mul_carry = 1'b0;
    forever begin
      @(negedge clk);
      if (mul_val && mul_rdy && !rst) begin
        issue_cnt++;
        chk_vec("issue_operand", mul_dat, model_op);
        resp = '0; cy = 1'b0;
        if (mode == M_MONT) begin
          a = op_int(mul_dat) % MOD_N;
          s = (((a * a) % MOD_N) * rinv) % MOD_N;
          resp[0] = 17'(s + MOD_N);
        end else if (mode == M_FORCE) begin
          resp = two_words(f_w0, f_w1);
          cy = f_cy;
        end else begin
          for (int i = 0; i < NUM_WRDS; i++) resp[i] = 17'($urandom_range(0, 17'h1FFFF));
          cy = ($urandom_range(0, 3) == 0);
        end
        model_cnt++;
        if (cy || model_cnt >= BOUNDARY_THRESHOLD) begin
          model_op = norm_ref(resp);
          model_cnt = 0;
        end else begin
          model_op = resp;
        end
        @(posedge clk);
        repeat (mul_lat - 1) @(posedge clk);
        #1; mul_rval = 1'b1; mul_rdat = flat_t'(resp); mul_carry = cy;
        @(posedge clk);
        #1; mul_rval = 1'b0; mul_rdat = '0; mul_carry = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_cmd(input int unsigned t, input redun0_t s);
    @(posedge clk); #1;
    model_op = s; model_cnt = 0; issue_cnt = 0;
    start = 1'b1; t_in = T_LEN'(t); sq_in = flat_t'(s);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit ok);
    lat = 1; ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      if (done === 1'b1) ok = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    chk_int("done_seen", ok, 1);
  endtask

  initial begin : main
    vec_t        tbl[7];
    int          lat;
    bit          ok;
    redun0_t     rec;
    redun0_t     rs;
    int unsigned tt;

    rst = 1'b1; start = 1'b0; t_in = '0; sq_in = '0;
    rinv = modpow(64'd65536, MOD_N - 2);

    //         t  sq           mode     lat w0        w1 cy mont ew0      ew1 plain lat
    tbl[0] = '{0, two_words(5, 0), M_MONT,  4, 0,       0, 0, 0,  5,      0,  0,   2};
    tbl[1] = '{3, to_mont(2),      M_MONT,  4, 0,       0, 0, 1,  0,      0,  256, -1};
    tbl[2] = '{1, two_words(7, 0), M_FORCE, 3, 'h1FFFF, 0, 1, 0,  'hFFFF, 1,  0,   -1};
    tbl[3] = '{2, to_mont(3),      M_MONT,  1, 0,       0, 0, 1,  0,      0,  81,  -1};
    tbl[4] = '{4, to_mont(2),      M_MONT,  2, 0,       0, 0, 1,  0,      0,  15,  -1};
    tbl[5] = '{1, two_words(9, 0), M_FORCE, 2, 'h1FFFF, 0, 0, 0,  'h1FFFF, 0, 0,   -1};
    tbl[6] = '{2, two_words(9, 0), M_FORCE, 2, 'h1FFFF, 0, 0, 0,  'hFFFF, 1,  0,   -1};

    repeat (3) @(posedge clk);
    #1;
    chk_int("reset_busy", busy, 0);
    chk_int("reset_done", done, 0);
    chk_int("reset_iter", iter, 0);
    chk_int("reset_mul_val", mul_val, 0);
    chk_vec("reset_sq", sq_out, '0);
    chk_vec("reset_mul_dat", mul_dat, '0);
    rst = 1'b0;

    for (int k = 0; k < 7; k++) begin
      mode = tbl[k].mode; mul_lat = tbl[k].lat;
      f_w0 = tbl[k].f_w0; f_w1 = tbl[k].f_w1; f_cy = tbl[k].f_cy;
      start_cmd(tbl[k].t, tbl[k].sq);
      chk_int("busy_after_start", busy, 1);
      wait_done(lat, ok);
      chk_int("busy_at_done", busy, 0);
      chk_int("iter", iter, tbl[k].t);
      chk_int("issues", issue_cnt, tbl[k].t);
      chk_vec("result_vs_model", sq_out, model_op);
      if (tbl[k].by_mont) chk_int("from_mont", from_mont(sq_out), tbl[k].exp_plain);
      else chk_vec("result_exact", sq_out, two_words(tbl[k].exp_w0, tbl[k].exp_w1));
      if (tbl[k].exp_lat >= 0) chk_int("done_latency", lat, tbl[k].exp_lat);
    end

    // Ready held low for 10 cycles in ISSUE: request must hold steady with no extra issues.
    mode = M_MONT; mul_lat = 3; rdy_level = 1'b0;
    repeat (2) @(posedge clk);
    start_cmd(2, to_mont(5));
    @(negedge clk);
    chk_int("stall_val_up", mul_val, 1);
    chk_vec("stall_dat", mul_dat, to_mont(5));
    rec = mul_dat;
    repeat (10) begin
      @(negedge clk);
      chk_int("stall_val_hold", mul_val, 1);
      chk_vec("stall_dat_hold", mul_dat, rec);
    end
    chk_int("stall_no_issue", issue_cnt, 0);
    rdy_level = 1'b1;
    @(posedge clk); #1;
    wait_done(lat, ok);
    chk_int("stall_issues", issue_cnt, 2);
    chk_int("stall_iter", iter, 2);
    chk_int("stall_from_mont", from_mont(sq_out), 625);

    // Reset while waiting on the 2nd squaring of T=5; the late result pulse must be ignored.
    mode = M_MONT; mul_lat = 8;
    start_cmd(5, to_mont(2));
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      if (issue_cnt == 2) ok = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk_int("rst_reach_iter2", ok, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_int("rst_busy", busy, 0);
    chk_int("rst_iter", iter, 0);
    chk_int("rst_mul_val", mul_val, 0);
    chk_vec("rst_mul_dat", mul_dat, '0);
    chk_vec("rst_sq", sq_out, '0);
    repeat (10) @(posedge clk);
    #1;
    chk_int("late_pulse_busy", busy, 0);
    chk_int("late_pulse_done", done, 0);
    chk_int("late_pulse_iter", iter, 0);
    chk_vec("late_pulse_op", mul_dat, '0);
    mul_lat = 2;
    start_cmd(1, to_mont(3));
    wait_done(lat, ok);
    chk_int("post_rst_iter", iter, 1);
    chk_int("post_rst_issues", issue_cnt, 1);
    chk_int("post_rst_from_mont", from_mont(sq_out), 9);

    // Start strobe with T=7 while a T=4 run is busy must have no effect.
    mul_lat = 3;
    start_cmd(4, to_mont(2));
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; t_in = T_LEN'(7); sq_in = flat_t'(to_mont(11));
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, ok);
    chk_int("busy_start_iter", iter, 4);
    chk_int("busy_start_issues", issue_cnt, 4);
    chk_int("busy_start_from_mont", from_mont(sq_out), 15);
    chk_vec("busy_start_vs_model", sq_out, model_op);

    // Randomized runs: random operands, carries, latencies and ready.
    mode = M_RAND; rdy_rand = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tt = $urandom_range(0, 6);
      for (int i = 0; i < NUM_WRDS; i++) rs[i] = 17'($urandom_range(0, 17'h1FFFF));
      mul_lat = $urandom_range(1, 5);
      start_cmd(tt, rs);
      wait_done(lat, ok);
      chk_int("rand_iter", iter, tt);
      chk_int("rand_issues", issue_cnt, tt);
      chk_vec("rand_result", sq_out, model_op);
    end
    rdy_rand = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
